// File: rtl/nt_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nt_bist_pkg
// Description : Shared types, defaults and the Galois LFSR/MISR step function
//               for the Nt-node subcircuit BIST drivers.
// Revision    : 1.0 - initial release
// ============================================================================
package nt_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest register the step function supports.
  localparam int          MAX_W    = 32;
  localparam logic [15:0] DEF_POLY = 16'hA011;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  // One Galois shift of a w-bit register held in the low bits of x:
  // shift left, and fold the polynomial in when the outgoing MSB was set.
  function automatic logic [MAX_W-1:0] galois_step(
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] poly,
    input int unsigned      w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] sh;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    top  = mask & ~(mask >> 1);
    sh   = {x[MAX_W-2:0], 1'b0} & mask;
    return ((x & top) != '0) ? (sh ^ (poly & mask)) : sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nt_misr.sv
`default_nettype none
// ============================================================================
// Module      : nt_misr
// Description : Single-input Galois MISR. Steps with din folded into bit 0
//               when en is high; clr zeroes the signature. nxt exposes the
//               value the register would take on an enabled step.
// Revision    : 1.0 - initial release
// ============================================================================
module nt_misr
  import nt_bist_pkg::*;
#(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = DEF_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  input  logic         clr,
  output logic [W-1:0] sig,
  output logic [W-1:0] nxt
);

  assign nxt = W'(galois_step(MAX_W'(sig), MAX_W'(POLY), W)) ^ {{(W-1){1'b0}}, din};

  // Signature register: reset/clear dominate, otherwise step on enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nt_subckt_bist_driver.sv
`default_nettype none
// ============================================================================
// Module      : nt_subckt_bist_driver
// Description : Drives an Nt-node subcircuit with LFSR patterns, compacts its
//               one-bit response in a MISR and compares against a golden
//               signature at the end of each run.
// Revision    : 1.0 - initial release
// ============================================================================
module nt_subckt_bist_driver
  import nt_bist_pkg::*;
#(
  parameter int                PAT_W   = 3,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] POLY    = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED    = DEF_SEED,
  parameter int                RUN_LEN = 1000,
  parameter int                LATENCY = 2
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] golden_sig,
  input  logic              resp_in,
  output logic [PAT_W-1:0]  pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LFSR_W-1:0] signature
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);

  state_t              state;
  state_t              state_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_step;
  logic [CNT_W-1:0]    pat_cnt;
  logic [LATENCY-1:0]  vld_pipe;
  logic [LATENCY-1:0]  vld_pipe_d;
  logic [LATENCY-1:0]  last_pipe;
  logic [LATENCY-1:0]  last_pipe_d;
  logic [LFSR_W-1:0]   misr_nxt;
  logic                start_ok;
  logic                run_cyc;
  logic                last_pat;
  logic                capture;
  logic                last_cap;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign run_cyc   = (state == RUN);
  assign last_pat  = run_cyc && (pat_cnt == CNT_W'(RUN_LEN - 1));
  assign capture   = vld_pipe[LATENCY-1];
  assign last_cap  = last_pipe[LATENCY-1];
  assign lfsr_step = LFSR_W'(galois_step(MAX_W'(lfsr), MAX_W'(POLY), LFSR_W));

  // The valid pipe marks which edges carry a response; the last pipe tags
  // the final pattern so its capture edge can close the run.
  if (LATENCY == 1) begin : g_pipe_one
    assign vld_pipe_d  = run_cyc;
    assign last_pipe_d = last_pat;
  end else begin : g_pipe_multi
    assign vld_pipe_d  = {vld_pipe[LATENCY-2:0], run_cyc};
    assign last_pipe_d = {last_pipe[LATENCY-2:0], last_pat};
  end

  // State register.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_pat) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_cap) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start_ok) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pattern generator, pattern counter, capture pipes and pass flag.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      lfsr      <= '0;
      pat_cnt   <= '0;
      pat_out   <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      pass      <= 1'b0;
    end else begin
      vld_pipe  <= vld_pipe_d;
      last_pipe <= last_pipe_d;
      if (start_ok) begin
        lfsr    <= SEED;
        pat_cnt <= '0;
        pat_out <= SEED[PAT_W-1:0];
        pass    <= 1'b0;
      end else if (run_cyc) begin
        lfsr    <= lfsr_step;
        pat_cnt <= pat_cnt + CNT_W'(1);
        pat_out <= last_pat ? '0 : lfsr_step[PAT_W-1:0];
      end else begin
        pat_out <= '0;
      end
      // Compare against the value the MISR takes on this final capture.
      if (last_cap) begin
        pass <= (misr_nxt == golden_sig);
      end
    end
  end

  nt_misr #(
    .W    (LFSR_W),
    .POLY (POLY)
  ) u_misr (
    .clk (I1470_clk),
    .rst (I1477_rst),
    .en  (capture),
    .din (resp_in),
    .clr (start_ok),
    .sig (signature),
    .nxt (misr_nxt)
  );

endmodule
`default_nettype wire
